// File: rtl/usb_bulk_pkg.sv
// Shared constants and FSM encoding for the USB bulk endpoint buffers.
package usb_bulk_pkg;

   localparam int unsigned MAX_PKT_HS = 512;
   localparam int unsigned MAX_PKT_FS = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RECV  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/usb_pkt_ram.sv
// Simple dual-port packet RAM: one write port, one registered read port with enable.
module usb_pkt_ram #(
   parameter int unsigned ADDR_WIDTH = 9
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [7:0]            wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [7:0]            rdata
);

   logic [7:0] mem [2**ADDR_WIDTH];

   // rdata holds while re is low so it can act as a stall buffer.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/bulk_out_pkt_rx.sv
// Bulk OUT packet buffer: captures one OUT packet, commits it on a clean end of transaction,
// then replays it as an AXI-Stream byte stream.
module bulk_out_pkt_rx
   import usb_bulk_pkg::*;
#(
   parameter int unsigned MAX_PACKET_SIZE = MAX_PKT_HS,
   parameter int unsigned ADDR_WIDTH      = 9,
   parameter bit          SHORT_TLAST     = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  blk_out_xfer_i,
   output logic                  blk_xfer_out_ready_read_o,
   input  logic [7:0]            blk_xfer_out_data_i,
   input  logic                  blk_xfer_out_data_valid_i,
   input  logic                  usb_crc_error_i,
   output logic                  m_axis_tvalid_o,
   input  logic                  m_axis_tready_i,
   output logic [7:0]            m_axis_tdata_o,
   output logic                  m_axis_tlast_o,
   output logic [ADDR_WIDTH:0]   level_o,
   output logic                  overflow_o
);

   localparam int unsigned CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] MaxCnt = CW'(MAX_PACKET_SIZE);
   localparam logic [CW-1:0] CntOne = {{ADDR_WIDTH{1'b0}}, 1'b1};

   state_t          state_q, state_d;
   logic            xfer_q;
   logic [CW-1:0]   wcnt_q, wcnt_d;
   logic [CW-1:0]   len_q, len_d;
   logic            short_q, short_d;
   logic            drop_q, drop_d;
   logic            ovf_q, ovf_d;
   logic [CW-1:0]   rd_idx_q, rd_idx_d;
   logic [CW-1:0]   acc_q, acc_d;
   logic            p_valid_q, p_valid_d;
   logic            p_last_q, p_last_d;
   logic            tvalid_q, tvalid_d;
   logic [7:0]      tdata_q, tdata_d;
   logic            tlast_q, tlast_d;
   logic [7:0]      rdata;

   logic            recv, drain;
   logic            xfer_rise, xfer_fall;
   logic            wr_en, ovf_byte, drop_now;
   logic [CW-1:0]   wcnt_inc;
   logic            accept, last_accept, out_load, rd_en;

   assign recv      = (state_q == ST_RECV);
   assign drain     = (state_q == ST_DRAIN);
   assign xfer_rise = blk_out_xfer_i & ~xfer_q;
   assign xfer_fall = ~blk_out_xfer_i & xfer_q;

   // Writes are capped at MaxCnt, so the RAM address never wraps.
   assign wr_en    = recv & blk_xfer_out_data_valid_i & (wcnt_q != MaxCnt);
   assign ovf_byte = recv & blk_xfer_out_data_valid_i & (wcnt_q == MaxCnt);
   assign wcnt_inc = wr_en ? wcnt_q + CntOne : wcnt_q;
   assign drop_now = drop_q | usb_crc_error_i | ovf_byte;

   assign accept      = tvalid_q & m_axis_tready_i;
   assign last_accept = accept & (acc_q == len_q - CntOne);
   assign out_load    = p_valid_q & (~tvalid_q | m_axis_tready_i);
   // Fetch when the RAM output stage is empty or being drained this cycle.
   assign rd_en       = drain & (rd_idx_q != len_q) & (~p_valid_q | out_load);

   usb_pkt_ram #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_ram (
      .clk  (clk),
      .we   (wr_en),
      .waddr(wcnt_q[ADDR_WIDTH-1:0]),
      .wdata(blk_xfer_out_data_i),
      .re   (rd_en),
      .raddr(rd_idx_q[ADDR_WIDTH-1:0]),
      .rdata(rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin : next_state
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (xfer_rise) state_d = ST_RECV;
         ST_RECV: begin
            if (xfer_fall) begin
               state_d = (drop_now || wcnt_inc == '0) ? ST_IDLE : ST_DRAIN;
            end
         end
         ST_DRAIN: if (last_accept) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin : outputs
      blk_xfer_out_ready_read_o = (state_q == ST_IDLE);
      level_o                   = drain ? len_q - acc_q : '0;
   end

   always_comb begin : datapath
      wcnt_d    = wcnt_q;
      len_d     = len_q;
      short_d   = short_q;
      drop_d    = drop_q;
      ovf_d     = ovf_q | ovf_byte;
      rd_idx_d  = rd_idx_q;
      acc_d     = acc_q;
      p_valid_d = p_valid_q;
      p_last_d  = p_last_q;
      tvalid_d  = tvalid_q;
      tdata_d   = tdata_q;
      tlast_d   = tlast_q;

      if (state_q == ST_IDLE && xfer_rise) begin
         wcnt_d = '0;
         drop_d = 1'b0;
      end

      // len/short track the running count; they are only consumed once DRAIN is entered.
      if (recv) begin
         wcnt_d    = wcnt_inc;
         drop_d    = drop_now;
         len_d     = wcnt_inc;
         short_d   = (wcnt_inc < MaxCnt);
         rd_idx_d  = '0;
         acc_d     = '0;
         p_valid_d = 1'b0;
      end

      if (drain) begin
         if (rd_en) begin
            rd_idx_d  = rd_idx_q + CntOne;
            p_valid_d = 1'b1;
            p_last_d  = (rd_idx_q == len_q - CntOne);
         end else if (out_load) begin
            p_valid_d = 1'b0;
         end

         if (out_load) begin
            tvalid_d = 1'b1;
            tdata_d  = rdata;
            tlast_d  = SHORT_TLAST & short_q & p_last_q;
         end else if (accept) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
         end

         if (accept) begin
            acc_d = acc_q + CntOne;
         end

         if (last_accept) begin
            tvalid_d  = 1'b0;
            tlast_d   = 1'b0;
            p_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xfer_q    <= 1'b0;
         wcnt_q    <= '0;
         len_q     <= '0;
         short_q   <= 1'b0;
         drop_q    <= 1'b0;
         ovf_q     <= 1'b0;
         rd_idx_q  <= '0;
         acc_q     <= '0;
         p_valid_q <= 1'b0;
         p_last_q  <= 1'b0;
         tvalid_q  <= 1'b0;
         tdata_q   <= '0;
         tlast_q   <= 1'b0;
      end else begin
         xfer_q    <= blk_out_xfer_i;
         wcnt_q    <= wcnt_d;
         len_q     <= len_d;
         short_q   <= short_d;
         drop_q    <= drop_d;
         ovf_q     <= ovf_d;
         rd_idx_q  <= rd_idx_d;
         acc_q     <= acc_d;
         p_valid_q <= p_valid_d;
         p_last_q  <= p_last_d;
         tvalid_q  <= tvalid_d;
         tdata_q   <= tdata_d;
         tlast_q   <= tlast_d;
      end
   end

   assign m_axis_tvalid_o = tvalid_q;
   assign m_axis_tdata_o  = tdata_q;
   assign m_axis_tlast_o  = tlast_q;
   assign overflow_o      = ovf_q;

endmodule

// File: tb/tb_bulk_out_pkt_rx.sv
// Directed bench for bulk_out_pkt_rx: packet table plus reset-mid-drain sequence.
module tb_bulk_out_pkt_rx;

   localparam int unsigned MPS = 512;
   localparam int unsigned AW  = 9;

   logic          clk = 1'b0;
   logic          rst;
   logic          xfer;
   logic          ready_read;
   logic [7:0]    data;
   logic          data_valid;
   logic          crc_err;
   logic          tvalid;
   logic          tready;
   logic [7:0]    tdata;
   logic          tlast;
   logic [AW:0]   level;
   logic          ovf;

   int checks   = 0;
   int failures = 0;

   bulk_out_pkt_rx #(
      .MAX_PACKET_SIZE(MPS),
      .ADDR_WIDTH     (AW),
      .SHORT_TLAST    (1'b1)
   ) dut (
      .clk                      (clk),
      .rst                      (rst),
      .blk_out_xfer_i           (xfer),
      .blk_xfer_out_ready_read_o(ready_read),
      .blk_xfer_out_data_i      (data),
      .blk_xfer_out_data_valid_i(data_valid),
      .usb_crc_error_i          (crc_err),
      .m_axis_tvalid_o          (tvalid),
      .m_axis_tready_i          (tready),
      .m_axis_tdata_o           (tdata),
      .m_axis_tlast_o           (tlast),
      .level_o                  (level),
      .overflow_o               (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      int len;
      int kind;
      int crc_at;
      bit stall;
      int exp_n;
      bit exp_ovf;
   } vec_t;

   vec_t        vecs[7];
   logic [8:0]  rx_q[$];
   int          exp_len  = 0;
   bit          level_en = 1'b0;
   bit          stall_mode = 1'b0;
   int          cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] gen(input int kind, input int i);
      case (kind)
         0:       return 8'(i);
         1:       return 8'(32'hA1 + i);
         2:       return 8'(32'h11 * (i + 1));
         default: return 8'(32'h5A ^ (i * 37));
      endcase
   endfunction

   // tready: always 1, or the repeating 1-0-0-1 pattern
   initial begin
      tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         tready = stall_mode ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      end
   end

   // Monitor at negedge: stability under stall, level tracking, capture of accepted bytes.
   bit         stalled_prev = 1'b0;
   logic [7:0] prev_data;
   logic       prev_last;
   always @(negedge clk) begin
      if (rst) begin
         stalled_prev = 1'b0;
      end else begin
         if (stalled_prev) begin
            chk("stall_tvalid", 32'(tvalid), 32'd1);
            chk("stall_tdata", 32'(tdata), 32'(prev_data));
            chk("stall_tlast", 32'(tlast), 32'(prev_last));
         end
         if (tvalid && level_en) begin
            chk("level", 32'(level), 32'(exp_len - rx_q.size()));
         end
         if (tvalid && tready) rx_q.push_back({tlast, tdata});
         stalled_prev = tvalid && !tready;
         prev_data    = tdata;
         prev_last    = tlast;
      end
   end

   task automatic send_pkt(input int len, input int kind, input int crc_at, input int exp_n);
      int cycles;
      cycles = (len < 10) ? 10 : len;
      @(posedge clk);
      #1 xfer = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         data_valid = (i < len);
         data       = (i < len) ? gen(kind, i) : 8'h00;
         crc_err    = (i == crc_at);
         if (i == 0) begin
            @(negedge clk);
            chk("ready_read_in_recv", 32'(ready_read), 32'd0);
         end
      end
      @(posedge clk);
      #1;
      xfer       = 1'b0;
      data_valid = 1'b0;
      crc_err    = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("ready_read_after_fall", 32'(ready_read), 32'(exp_n == 0));
   endtask

   task automatic wait_rx(input int n, input int budget);
      int waited;
      waited = 0;
      while (rx_q.size() < n && waited < budget) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= budget) chk("rx_timeout", 32'(rx_q.size()), 32'(n));
      repeat (8) @(negedge clk);
   endtask

   task automatic check_bytes(input int len, input int kind, input int n);
      for (int j = 0; j < n && j < rx_q.size(); j++) begin
         chk($sformatf("tdata[%0d]", j), 32'(rx_q[j][7:0]), 32'(gen(kind, j)));
         chk($sformatf("tlast[%0d]", j), 32'(rx_q[j][8]),
             32'((len < MPS) && (j == len - 1)));
      end
   endtask

   initial begin
      vecs[0] = '{len: 512, kind: 0, crc_at: -1, stall: 1'b0, exp_n: 512, exp_ovf: 1'b0};
      vecs[1] = '{len: 5,   kind: 1, crc_at: -1, stall: 1'b0, exp_n: 5,   exp_ovf: 1'b0};
      vecs[2] = '{len: 8,   kind: 2, crc_at: 4,  stall: 1'b0, exp_n: 0,   exp_ovf: 1'b0};
      vecs[3] = '{len: 0,   kind: 0, crc_at: -1, stall: 1'b0, exp_n: 0,   exp_ovf: 1'b0};
      vecs[4] = '{len: 100, kind: 0, crc_at: -1, stall: 1'b1, exp_n: 100, exp_ovf: 1'b0};
      vecs[5] = '{len: 513, kind: 0, crc_at: -1, stall: 1'b0, exp_n: 0,   exp_ovf: 1'b1};
      vecs[6] = '{len: 3,   kind: 2, crc_at: -1, stall: 1'b0, exp_n: 3,   exp_ovf: 1'b1};

      rst        = 1'b1;
      xfer       = 1'b0;
      data       = 8'h00;
      data_valid = 1'b0;
      crc_err    = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready_read", 32'(ready_read), 32'd1);
      chk("rst_tvalid", 32'(tvalid), 32'd0);
      chk("rst_tdata", 32'(tdata), 32'd0);
      chk("rst_tlast", 32'(tlast), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_overflow", 32'(ovf), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      for (int v = 0; v < 7; v++) begin
         rx_q.delete();
         stall_mode = vecs[v].stall;
         exp_len    = vecs[v].len;
         level_en   = 1'b1;
         send_pkt(vecs[v].len, vecs[v].kind, vecs[v].crc_at, vecs[v].exp_n);
         wait_rx(vecs[v].exp_n, vecs[v].len * 4 + 100);
         chk($sformatf("vec%0d_count", v), 32'(rx_q.size()), 32'(vecs[v].exp_n));
         check_bytes(vecs[v].len, vecs[v].kind, vecs[v].exp_n);
         chk($sformatf("vec%0d_overflow", v), 32'(ovf), 32'(vecs[v].exp_ovf));
         chk($sformatf("vec%0d_ready_read", v), 32'(ready_read), 32'd1);
         chk($sformatf("vec%0d_level_idle", v), 32'(level), 32'd0);
         chk($sformatf("vec%0d_tvalid_idle", v), 32'(tvalid), 32'd0);
      end
      stall_mode = 1'b0;

      // Reset in the middle of a 64-byte drain, then a fresh 2-byte packet.
      rx_q.delete();
      exp_len = 64;
      send_pkt(64, 0, -1, 64);
      begin
         int waited;
         waited = 0;
         while (rx_q.size() < 40 && waited < 400) begin
            @(posedge clk);
            waited++;
         end
         chk("mid_drain_reached", 32'(rx_q.size() >= 40), 32'd1);
      end
      level_en = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_tvalid", 32'(tvalid), 32'd0);
      chk("rst_mid_level", 32'(level), 32'd0);
      chk("rst_mid_ready_read", 32'(ready_read), 32'd1);
      chk("rst_mid_overflow", 32'(ovf), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      rx_q.delete();
      exp_len  = 2;
      level_en = 1'b1;
      send_pkt(2, 3, -1, 2);
      wait_rx(2, 100);
      chk("post_rst_count", 32'(rx_q.size()), 32'd2);
      check_bytes(2, 3, 2);
      chk("post_rst_ready_read", 32'(ready_read), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
